// File: rtl/regsched_pkg.sv
// Shared types and helpers for the register-file writeback scheduler.
// The optional feature macro REGSCHED_FIXED_PRIO_EN is consumed by regfile_wb_scheduler.
package regsched_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t addr;
    reg_data_t data;
  } wb_req_t;

  // Only the low four address bits select a tracked scoreboard entry.
  function automatic logic [3:0] reg_idx(input reg_addr_t addr);
    return addr[3:0];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: the search begins one past ptr.
// A constant ptr of N-1 turns it into fixed priority with index 0 highest.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int j;
    logic [IDX_W-1:0] jj;
    j   = 0;
    jj  = '0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j  = (int'(ptr) + k) % N;
      jj = IDX_W'(j);
      if (!any && req[jj]) begin
        any     = 1'b1;
        gnt[jj] = 1'b1;
        idx     = jj;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Arbitrates writeback requesters onto the single register-file write port and
// tracks pending destinations for hazard stalls. Macro: REGSCHED_FIXED_PRIO_EN.
module regfile_wb_scheduler
  import regsched_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int NUM_REGS = regsched_pkg::NUM_REGS,
  parameter int ADDR_W   = regsched_pkg::ADDR_W,
  parameter int DATA_W   = regsched_pkg::DATA_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clk_enable,
  input  logic                      iss_valid,
  input  logic [ADDR_W-1:0]         iss_rd,
  input  logic [ADDR_W-1:0]         iss_rs1,
  input  logic [ADDR_W-1:0]         iss_rs2,
  output logic                      iss_ready,
  input  logic                      sb_flush,
  input  logic [NUM_REQ-1:0]        wb_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] wb_addr,
  input  logic [NUM_REQ*DATA_W-1:0] wb_data,
  output logic [NUM_REQ-1:0]        wb_ready,
  output logic                      rf_write_enable,
  output logic [ADDR_W-1:0]         rf_write_addr,
  output logic [DATA_W-1:0]         rf_data
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0]   ptr;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic               xfer;
  logic               issue_fire;
  wb_req_t            sel_req;

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0]   rf_data_q, rf_data_d;

`ifdef REGSCHED_FIXED_PRIO_EN
  assign ptr = IDX_W'(NUM_REQ - 1);
`else
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  assign ptr      = rr_ptr_q;
  assign rr_ptr_d = xfer ? gnt_idx : rr_ptr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q <= IDX_W'(NUM_REQ - 1);
    end else if (clk_enable) begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req (wb_valid),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  assign wb_ready = clk_enable ? gnt : '0;
  assign xfer     = clk_enable & gnt_any;

  assign sel_req.valid = gnt_any;
  assign sel_req.addr  = reg_addr_t'(wb_addr[gnt_idx*ADDR_W +: ADDR_W]);
  assign sel_req.data  = reg_data_t'(wb_data[gnt_idx*DATA_W +: DATA_W]);

  assign iss_ready = clk_enable & ~busy_q[reg_idx(iss_rs1)]
                                & ~busy_q[reg_idx(iss_rs2)]
                                & ~busy_q[reg_idx(iss_rd)];
  assign issue_fire = iss_valid & iss_ready;

  // A grant to x0 is consumed but never reaches the register file.
  always_comb begin
    rf_we_d   = xfer & (reg_idx(sel_req.addr) != 4'd0);
    rf_addr_d = rf_we_d ? sel_req.addr : rf_addr_q;
    rf_data_d = rf_we_d ? sel_req.data : rf_data_q;
  end

  // Clear on commit, set on issue; flush wins over both.
  always_comb begin
    busy_d = busy_q;
    if (rf_we_q) busy_d[reg_idx(rf_addr_q)] = 1'b0;
    if (issue_fire && reg_idx(iss_rd) != 4'd0) busy_d[reg_idx(iss_rd)] = 1'b1;
    if (sb_flush) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q    <= '0;
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else if (clk_enable) begin
      busy_q    <= busy_d;
      rf_we_q   <= rf_we_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
    end
  end

  assign rf_write_enable = rf_we_q;
  assign rf_write_addr   = rf_addr_q;
  assign rf_data         = rf_data_q;

endmodule
